// File: rtl/scalar_branch_unit_if.sv
// Signal bundle between the scalar ALU / execute stage and the branch resolution unit.
// The master side drives compare flags and branches; the slave side is the resolver.
interface scalar_branch_unit_if #(
  parameter int PC_W  = 36,
  parameter int CNT_W = 16
);
  logic             cmp_issue;
  logic             cmp_valid;
  logic             nz, ez, lz, gz, le, ge;
  logic             br_valid;
  logic             br_ready;
  logic [2:0]       br_cond;
  logic             br_pred;
  logic [PC_W-1:0]  br_target;
  logic [PC_W-1:0]  br_fallthru;
  logic             flush;
  logic             resolved_valid;
  logic             resolved_taken;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic [CNT_W-1:0] mispredict_cnt;

  modport master (
    output cmp_issue, cmp_valid, nz, ez, lz, gz, le, ge,
    output br_valid, br_cond, br_pred, br_target, br_fallthru, flush,
    input  br_ready, resolved_valid, resolved_taken, redirect_valid, redirect_pc, mispredict_cnt
  );

  modport slave (
    input  cmp_issue, cmp_valid, nz, ez, lz, gz, le, ge,
    input  br_valid, br_cond, br_pred, br_target, br_fallthru, flush,
    output br_ready, resolved_valid, resolved_taken, redirect_valid, redirect_pc, mispredict_cnt
  );
endinterface

// File: rtl/scalar_branch_unit.sv
// Branch condition resolution behind the scalar ALU: latches compare flags, stalls a branch
// on an outstanding compare, reports the outcome and redirects fetch on a misprediction.
//
// state | meaning
// IDLE  | br_ready=1; an accepted branch resolves now unless an older compare is outstanding
// HOLD  | br_ready=0; branch parked in the hold buffer until the compare's flags arrive
module scalar_branch_unit #(
  parameter int PC_W  = 36,
  parameter int CNT_W = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  scalar_branch_unit_if.slave bus
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;
  // {nz, ez, lz, gz, le, ge} for a zero compare result
  localparam logic [5:0] FR_RESET = 6'b010011;

  logic [0:0]      state;
  logic            pend;
  logic [5:0]      fr;
  logic [5:0]      flags_in;
  logic [5:0]      flags_sel;
  logic [2:0]      hold_cond;
  logic            hold_pred;
  logic [PC_W-1:0] hold_target;
  logic [PC_W-1:0] hold_fallthru;
  logic [2:0]      ev_cond;
  logic            ev_pred;
  logic [PC_W-1:0] ev_target;
  logic [PC_W-1:0] ev_fallthru;
  logic            resolve;
  logic            park;
  logic            taken;
  logic            mispred;

  assign flags_in     = {bus.nz, bus.ez, bus.lz, bus.gz, bus.le, bus.ge};
  assign flags_sel    = bus.cmp_valid ? flags_in : fr;
  assign bus.br_ready = (state == S_IDLE);

  always_comb begin
    ev_cond     = bus.br_cond;
    ev_pred     = bus.br_pred;
    ev_target   = bus.br_target;
    ev_fallthru = bus.br_fallthru;
    resolve     = 1'b0;
    park        = 1'b0;
    if (state == S_HOLD) begin
      ev_cond     = hold_cond;
      ev_pred     = hold_pred;
      ev_target   = hold_target;
      ev_fallthru = hold_fallthru;
      resolve     = bus.cmp_valid && !bus.flush;
    end else if (bus.br_valid && !bus.flush) begin
      resolve = !pend || bus.cmp_valid;
      park    = pend && !bus.cmp_valid;
    end
  end

  always_comb begin
    case (ev_cond)
      3'b000:  taken = flags_sel[5];
      3'b001:  taken = flags_sel[4];
      3'b010:  taken = flags_sel[3];
      3'b011:  taken = flags_sel[2];
      3'b100:  taken = flags_sel[1];
      3'b101:  taken = flags_sel[0];
      3'b110:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  assign mispred = (taken != ev_pred);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pend  <= 1'b0;
      fr    <= FR_RESET;
    end else begin
      if (bus.cmp_valid) fr <= flags_in;
      // a same-cycle issue wins over valid: the new compare is now the outstanding one
      if (bus.flush)          pend <= 1'b0;
      else if (bus.cmp_issue) pend <= 1'b1;
      else if (bus.cmp_valid) pend <= 1'b0;
      if (bus.flush)                               state <= S_IDLE;
      else if (park)                               state <= S_HOLD;
      else if (state == S_HOLD && bus.cmp_valid)   state <= S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cond     <= 3'b000;
      hold_pred     <= 1'b0;
      hold_target   <= '0;
      hold_fallthru <= '0;
    end else if (park) begin
      hold_cond     <= bus.br_cond;
      hold_pred     <= bus.br_pred;
      hold_target   <= bus.br_target;
      hold_fallthru <= bus.br_fallthru;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.resolved_valid <= 1'b0;
      bus.resolved_taken <= 1'b0;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
      bus.mispredict_cnt <= '0;
    end else begin
      bus.resolved_valid <= resolve;
      bus.resolved_taken <= resolve && taken;
      bus.redirect_valid <= resolve && mispred;
      if (resolve && mispred) begin
        bus.redirect_pc <= taken ? ev_target : ev_fallthru;
        if (bus.mispredict_cnt != '1) bus.mispredict_cnt <= bus.mispredict_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_scalar_branch_unit.sv
// Bench for scalar_branch_unit: constant vector table, directed multi-cycle sequences,
// and randomized traffic checked against a transaction-level reference model.
module tb_scalar_branch_unit;
  localparam int PC_W  = 36;
  localparam int CNT_W = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic nz, ez, lz, gz, le, ge;
  } flags_t;

  typedef struct packed {
    logic [2:0]      cond;
    logic            pred;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] fallthru;
  } br_t;

  typedef struct {
    logic [5:0] flags;
    logic [2:0] cond;
    logic       pred;
    logic       exp_taken;
    logic       exp_redir;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scalar_branch_unit_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();
  scalar_branch_unit #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  flags_t          m_fr;
  bit              m_pend;
  bit              m_hold;
  br_t             m_h;
  bit              e_rv, e_rt, e_dv;
  logic [PC_W-1:0] e_pc;
  int              e_cnt;
  int              dly;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit outcome(input logic [2:0] c, input flags_t f);
    case (c)
      3'd0:    return f.nz;
      3'd1:    return f.ez;
      3'd2:    return f.lz;
      3'd3:    return f.gz;
      3'd4:    return f.le;
      3'd5:    return f.ge;
      3'd6:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_fr   = '{nz: 1'b0, ez: 1'b1, lz: 1'b0, gz: 1'b0, le: 1'b1, ge: 1'b1};
    m_pend = 0;
    m_hold = 0;
    e_rv   = 0;
    e_rt   = 0;
    e_dv   = 0;
    e_pc   = '0;
    e_cnt  = 0;
    dly    = -1;
  endtask

  task automatic idle_inputs();
    bus.cmp_issue   = 0;
    bus.cmp_valid   = 0;
    {bus.nz, bus.ez, bus.lz, bus.gz, bus.le, bus.ge} = 6'b0;
    bus.br_valid    = 0;
    bus.br_cond     = 3'b0;
    bus.br_pred     = 0;
    bus.br_target   = '0;
    bus.br_fallthru = '0;
    bus.flush       = 0;
  endtask

  task automatic set_branch(input logic [2:0] c, input logic p, input logic [PC_W-1:0] t,
                            input logic [PC_W-1:0] f);
    bus.br_valid    = 1;
    bus.br_cond     = c;
    bus.br_pred     = p;
    bus.br_target   = t;
    bus.br_fallthru = f;
  endtask

  // One clock: predict from the current inputs, advance the edge, compare the outputs.
  task automatic cycle();
    flags_t fin, fs;
    br_t    b, rb;
    bit     res, t;
    fin = {bus.nz, bus.ez, bus.lz, bus.gz, bus.le, bus.ge};
    b   = {bus.br_cond, bus.br_pred, bus.br_target, bus.br_fallthru};
    rb  = b;
    chk1("br_ready", bus.br_ready, !m_hold);
    fs  = bus.cmp_valid ? fin : m_fr;
    res = 0;
    if (m_hold) begin
      if (bus.flush) m_hold = 0;
      else if (bus.cmp_valid) begin
        res = 1;
        rb = m_h;
        m_hold = 0;
      end
    end else if (bus.br_valid && !bus.flush) begin
      if (m_pend && !bus.cmp_valid) begin
        m_hold = 1;
        m_h = b;
      end else res = 1;
    end
    e_rv = res;
    e_dv = 0;
    e_rt = 0;
    if (res) begin
      t = outcome(rb.cond, fs);
      e_rt = t;
      if (t != rb.pred) begin
        e_dv = 1;
        e_pc = t ? rb.target : rb.fallthru;
        if (e_cnt < CNT_MAX) e_cnt++;
      end
    end
    if (bus.cmp_valid) m_fr = fin;
    if (bus.flush) m_pend = 0;
    else if (bus.cmp_issue) m_pend = 1;
    else if (bus.cmp_valid) m_pend = 0;
    @(posedge clk);
    #1;
    chk1("resolved_valid", bus.resolved_valid, e_rv);
    chk1("redirect_valid", bus.redirect_valid, e_dv);
    chkw("redirect_pc", 64'(bus.redirect_pc), 64'(e_pc));
    chkw("mispredict_cnt", 64'(bus.mispredict_cnt), 64'(e_cnt));
    if (e_rv) chk1("resolved_taken", bus.resolved_taken, e_rt);
  endtask

  task automatic rand_inputs(input bit allow_new);
    if (dly > 0) dly--;
    bus.cmp_valid = (dly == 0);
    if (bus.cmp_valid) dly = -1;
    {bus.nz, bus.ez, bus.lz, bus.gz, bus.le, bus.ge} = 6'($urandom);
    bus.cmp_issue = allow_new && (dly < 0) && ($urandom_range(0, 9) < 3);
    if (bus.cmp_issue) dly = int'($urandom_range(1, 4));
    bus.br_valid    = allow_new && ($urandom_range(0, 9) < 6);
    bus.br_cond     = 3'($urandom);
    bus.br_pred     = 1'($urandom);
    bus.br_target   = {4'($urandom), 32'($urandom)};
    bus.br_fallthru = {4'($urandom), 32'($urandom)};
    bus.flush       = allow_new && ($urandom_range(0, 99) < 4);
  endtask

  vec_t tbl[8];
  int   stalls;

  initial begin
    tbl[0] = '{6'b100101, 3'b011, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{6'b100101, 3'b010, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{6'b010011, 3'b001, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{6'b010011, 3'b000, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{6'b101010, 3'b100, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{6'b101010, 3'b101, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{6'b000000, 3'b110, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{6'b111111, 3'b111, 1'b1, 1'b0, 1'b1};

    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk1("reset br_ready", bus.br_ready, 1'b1);
    chk1("reset resolved_valid", bus.resolved_valid, 1'b0);
    chk1("reset resolved_taken", bus.resolved_taken, 1'b0);
    chk1("reset redirect_valid", bus.redirect_valid, 1'b0);
    chkw("reset redirect_pc", 64'(bus.redirect_pc), 64'h0);
    chkw("reset mispredict_cnt", 64'(bus.mispredict_cnt), 64'h0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // branch against the reset flag register (ez=1)
    set_branch(3'b001, 1'b0, 36'h100, 36'h104);
    cycle();
    idle_inputs();
    chk1("t1 taken", bus.resolved_taken, 1'b1);
    chk1("t1 redirect", bus.redirect_valid, 1'b1);
    chkw("t1 pc", 64'(bus.redirect_pc), 64'h100);
    chkw("t1 cnt", 64'(bus.mispredict_cnt), 64'h1);
    cycle();
    chk1("t1 pulse width", bus.resolved_valid, 1'b0);

    // 5 vs 7 forwarded on the same cycle as the branch: no stall
    bus.cmp_issue = 1;
    cycle();
    idle_inputs();
    bus.cmp_valid = 1;
    {bus.nz, bus.ez, bus.lz, bus.gz, bus.le, bus.ge} = 6'b101010;
    set_branch(3'b010, 1'b1, 36'h180, 36'h184);
    chk1("t2 ready", bus.br_ready, 1'b1);
    cycle();
    idle_inputs();
    chk1("t2 resolved", bus.resolved_valid, 1'b1);
    chk1("t2 taken", bus.resolved_taken, 1'b1);
    chk1("t2 no redirect", bus.redirect_valid, 1'b0);

    foreach (tbl[i]) begin
      bus.cmp_issue = 1;
      cycle();
      idle_inputs();
      bus.cmp_valid = 1;
      {bus.nz, bus.ez, bus.lz, bus.gz, bus.le, bus.ge} = tbl[i].flags;
      set_branch(tbl[i].cond, tbl[i].pred, 36'hA00 + 36'(i), 36'hB00 + 36'(i));
      cycle();
      idle_inputs();
      chk1($sformatf("tbl%0d taken", i), bus.resolved_taken, tbl[i].exp_taken);
      chk1($sformatf("tbl%0d redirect", i), bus.redirect_valid, tbl[i].exp_redir);
      if (tbl[i].exp_redir)
        chkw($sformatf("tbl%0d pc", i), 64'(bus.redirect_pc),
             tbl[i].exp_taken ? 64'hA00 + 64'(i) : 64'hB00 + 64'(i));
    end

    // branch stalls three cycles on a late compare, then falls through
    bus.cmp_issue = 1;
    cycle();
    idle_inputs();
    set_branch(3'b011, 1'b1, 36'h200, 36'h204);
    cycle();
    idle_inputs();
    stalls = 0;
    for (int i = 0; i < 3; i++) begin
      if (!bus.br_ready) stalls++;
      chk1("t3 no early resolve", bus.resolved_valid, 1'b0);
      if (i == 2) begin
        bus.cmp_valid = 1;
        {bus.nz, bus.ez, bus.lz, bus.gz, bus.le, bus.ge} = 6'b101010;
      end
      cycle();
      idle_inputs();
    end
    chkw("t3 stall cycles", 64'(stalls), 64'd3);
    chk1("t3 resolved", bus.resolved_valid, 1'b1);
    chk1("t3 taken", bus.resolved_taken, 1'b0);
    chk1("t3 redirect", bus.redirect_valid, 1'b1);
    chkw("t3 pc", 64'(bus.redirect_pc), 64'h204);
    chk1("t3 ready", bus.br_ready, 1'b1);

    // flush while holding; the late compare then only updates the flag register
    bus.cmp_issue = 1;
    cycle();
    idle_inputs();
    set_branch(3'b001, 1'b0, 36'h300, 36'h304);
    cycle();
    idle_inputs();
    cycle();
    bus.flush = 1;
    cycle();
    idle_inputs();
    chk1("t4 ready", bus.br_ready, 1'b1);
    chk1("t4 no resolve", bus.resolved_valid, 1'b0);
    chk1("t4 no redirect", bus.redirect_valid, 1'b0);
    bus.cmp_valid = 1;
    {bus.nz, bus.ez, bus.lz, bus.gz, bus.le, bus.ge} = 6'b100101;
    cycle();
    idle_inputs();
    chk1("t4 late valid quiet", bus.resolved_valid, 1'b0);
    set_branch(3'b000, 1'b1, 36'h310, 36'h314);
    cycle();
    idle_inputs();
    chk1("t4 fr updated", bus.resolved_taken, 1'b1);
    chk1("t4 fr no redirect", bus.redirect_valid, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      rand_inputs(1'b1);
      cycle();
    end
    for (int n = 0; n < 8; n++) begin
      rand_inputs(1'b0);
      cycle();
    end
    idle_inputs();
    bus.flush = 1;
    cycle();
    idle_inputs();
    chkw("drain done", 64'(dly < 0), 64'd1);

    // saturation of the mispredict counter
    set_branch(3'b110, 1'b0, 36'h400, 36'h404);
    for (int n = 0; n < 65540; n++) cycle();
    idle_inputs();
    chkw("t5 saturated", 64'(bus.mispredict_cnt), 64'hFFFF);
    set_branch(3'b111, 1'b1, 36'h410, 36'h414);
    cycle();
    idle_inputs();
    chkw("t5 stays", 64'(bus.mispredict_cnt), 64'hFFFF);
    chkw("t5 last pc", 64'(bus.redirect_pc), 64'h414);

    // asynchronous reset in the middle of HOLD
    bus.cmp_issue = 1;
    cycle();
    idle_inputs();
    set_branch(3'b101, 1'b0, 36'h500, 36'h504);
    cycle();
    idle_inputs();
    chk1("t6 in hold", bus.br_ready, 1'b0);
    #2;
    rst_n = 0;
    #1;
    chk1("t6 br_ready", bus.br_ready, 1'b1);
    chk1("t6 resolved_valid", bus.resolved_valid, 1'b0);
    chk1("t6 resolved_taken", bus.resolved_taken, 1'b0);
    chk1("t6 redirect_valid", bus.redirect_valid, 1'b0);
    chkw("t6 redirect_pc", 64'(bus.redirect_pc), 64'h0);
    chkw("t6 mispredict_cnt", 64'(bus.mispredict_cnt), 64'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    bus.cmp_valid = 1;
    {bus.nz, bus.ez, bus.lz, bus.gz, bus.le, bus.ge} = 6'b111111;
    cycle();
    idle_inputs();
    chk1("t6 held branch lost", bus.resolved_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/scalar_branch_unit.md
# scalar_branch_unit

Condition-resolution stage directly downstream of the scalar ALU. It latches the six compare flags (nz, ez, lz, gz, le, ge) that the ALU produces for a compare operation (op 4'b1000) and evaluates the branch sitting in execute against them. When a compare is still in flight it stalls that branch. It reports the actual outcome and drives a fetch redirect on a misprediction.

## Interface

**Parameters**
- PC_W, 36, width of branch target and fall-through addresses.
- CNT_W, 16, width of the saturating mispredict counter.

**Ports**
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- cmp_issue  in  1  a compare (op 4'b1000) enters the ALU this cycle.
- cmp_valid  in  1  ALU flags valid this cycle; arrives 1 or more cycles after the matching cmp_issue.
- nz, ez, lz, gz, le, ge  in  1 each  ALU compare flags, qualified by cmp_valid.
- br_valid  in  1  branch present in execute.
- br_ready  out  1  branch accepted this cycle when br_valid && br_ready.
- br_cond  in  3  condition select: 000 nz, 001 ez, 010 lz, 011 gz, 100 le, 101 ge, 110 always, 111 never.
- br_pred  in  1  predicted taken.
- br_target  in  PC_W  taken address.
- br_fallthru  in  PC_W  not-taken address.
- flush  in  1  synchronous kill from a later stage.
- resolved_valid  out  1  one-cycle pulse per resolved branch.
- resolved_taken  out  1  actual outcome, valid with resolved_valid.
- redirect_valid  out  1  one-cycle pulse on a misprediction.
- redirect_pc  out  PC_W  correct fetch address.
- mispredict_cnt  out  CNT_W  saturating misprediction count.

## Operation

**Flag register FR**
- Loaded with {nz, ez, lz, gz, le, ge} on every cycle with cmp_valid=1.
- Reset value is the "result zero" set: ez=le=ge=1, nz=lz=gz=0.

**Pending bit pend**
- Set on cmp_issue, cleared on cmp_valid.
- If cmp_issue and cmp_valid are both 1 in the same cycle, pend stays 1 (a new compare is now outstanding).
- At most one compare is outstanding at a time.

**Flag source for evaluation**
- cmp_valid=1: use the incoming flags (forwarded).
- Otherwise: use FR.
- A cmp_issue in the same cycle as a branch belongs to a younger instruction and does not stall that branch.

**FSM (2 states)**
- IDLE
  - br_ready=1.
  - On an accepted branch with pend=0 or cmp_valid=1: resolve this cycle, stay in IDLE.
  - On an accepted branch with pend=1 and cmp_valid=0: capture br_cond, br_pred, br_target and br_fallthru into a hold buffer, go to HOLD.
- HOLD
  - br_ready=0.
  - On cmp_valid: resolve the held branch using the forwarded flags, go to IDLE.
- flush (either state)
  - Go to IDLE, discard the held or accepted branch (no resolved/redirect pulse), clear pend.
  - FR is not changed. A cmp_valid in the flush cycle still loads FR.

**Resolution**
- taken = the flag selected by br_cond; 110 gives 1, 111 gives 0.
- resolved_valid=1 and resolved_taken=taken.
- If taken != br_pred:
  - redirect_valid=1.
  - redirect_pc = taken ? br_target : br_fallthru.
  - mispredict_cnt increments, saturating at all-ones.

## Timing

- All outputs are registered. Reset values: resolved_valid=0, resolved_taken=0, redirect_valid=0, redirect_pc=0, mispredict_cnt=0, state IDLE, pend=0.
- br_ready is decoded from state only, so it is 1 out of reset.
- Latency: a branch resolved in cycle N produces resolved_valid/redirect_valid in cycle N+1, each high for exactly one cycle.
- redirect_pc holds its value until the next misprediction.
- HOLD exit: cmp_valid in cycle M gives outputs in M+1 and br_ready=1 in M+1. A new branch can then be accepted in M+1.
- Reset asserted mid-HOLD: immediate return to the reset values above, and the held branch is lost.
- The counter never wraps: at all-ones, further mispredictions leave it unchanged.

## Test plan

1. Reset, then a branch with br_cond=001 (ez), br_pred=0, no compare issued → resolves against the reset FR (ez=1): resolved_taken=1, redirect_valid=1, redirect_pc=br_target=0x100, mispredict_cnt=1.
2. cmp_issue with A=5, B=7; cmp_valid next cycle carrying lz=1, le=1; a branch with br_cond=010, br_pred=1 in that same cycle → forwarded flags used, no stall, resolved_taken=1, no redirect.
3. cmp_issue, then a branch one cycle later while cmp_valid is delayed 3 cycles → br_ready=0 for 3 cycles, then resolved_valid the cycle after cmp_valid. For br_cond=011 with gz=0 and br_pred=1: redirect_pc=br_fallthru=0x204.
4. flush asserted while in HOLD → back to IDLE next cycle, no resolved/redirect pulse; a later cmp_valid only updates FR.
5. 65540 mispredicting branches with br_cond=110 and br_pred=0 → mispredict_cnt=0xFFFF and stays there.
6. rst_n dropped asynchronously mid-HOLD → all outputs 0 and br_ready=1 before the next clock edge.
